// File: rtl/wire_alu_pkg.sv
// Shared definitions for the wire-in/wire-out ALU engine: operation and FSM
// encodings plus bit positions inside the control and status wires.
package wire_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ACC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // control wire bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_OP_LSB = 1;
  localparam int CTRL_CLEAR  = 3;

  // status wire bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_DROP    = 3;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/wire_alu_shift_mul.sv
// Iterative shift-add multiplier: one multiplier bit per step, LSB first.
// load captures the operands and clears the product; step performs one
// iteration; last flags the step that consumes the final multiplier bit.
module wire_alu_shift_mul #(
  parameter int WIDTH = 32
) (
  input  logic             okClk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_lo,
  output logic             hi_nz,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  assign last    = step && (cnt == CW'(WIDTH - 1));
  assign prod_lo = prod[WIDTH-1:0];
  assign hi_nz   = |prod[2*WIDTH-1:WIDTH];

  // operand capture on load, one add/shift iteration per step
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wire_alu_engine.sv
// Compute stage between FrontPanel wire-ins and wire-outs (okClk domain).
// Host pulses start (rising edge of ctrl_in[0]) to run ADD/SUB/MUL/ACC on the
// latched operands; result and status are polled from the wire-outs.
// Optional build macro WIRE_ALU_SATURATE_EN clamps results on overflow
// instead of wrapping (overflow flag is reported either way).
module wire_alu_engine
  import wire_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             okClk,
  input  logic             rst_n,
  input  logic [31:0]      ctrl_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result_out,
  output logic [31:0]      status_out
);

`ifdef WIRE_ALU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  op_t              op_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             done_q, ovf_q, drop_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_p, clear_p;
  logic             mul_load, mul_step, mul_last, mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] raw_res;
  logic             ovf_c;
  logic             unused_ctrl;

  assign unused_ctrl = ^{ctrl_in[31:4], ctrl_q[2:1]};

  assign start_p = ctrl_in[CTRL_START] & ~ctrl_q[CTRL_START];
  assign clear_p = ctrl_in[CTRL_CLEAR] & ~ctrl_q[CTRL_CLEAR];

  assign mul_load = (state_q == S_IDLE) && start_p && !clear_p;
  assign mul_step = (state_q == S_EXEC) && (op_q == OP_MUL);

  // Overflow clamp: SUB underflow pins to zero, everything else to all-ones.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic ovf, input op_t op);
    logic [WIDTH-1:0] clamp;
    clamp = (op == OP_SUB) ? '0 : '1;
    return (SAT_EN && ovf) ? clamp : raw;
  endfunction

  wire_alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .okClk   (okClk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (op_a),
    .b       (op_b),
    .prod_lo (mul_lo),
    .hi_nz   (mul_hi),
    .last    (mul_last)
  );

  // next-state selection; a clear pulse always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_p) state_d = S_EXEC;
      S_EXEC:  if (op_q != OP_MUL || mul_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear_p) state_d = S_IDLE;
  end

  // raw result and overflow of the latched operation (ACC adds onto result_out)
  always_comb begin
    sum_ext = '0;
    raw_res = '0;
    ovf_c   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        raw_res = sum_ext[WIDTH-1:0];
        ovf_c   = sum_ext[WIDTH];
      end
      OP_SUB: begin
        raw_res = a_q - b_q;
        ovf_c   = (a_q < b_q);
      end
      OP_MUL: begin
        raw_res = mul_lo;
        ovf_c   = mul_hi;
      end
      default: begin
        sum_ext = {1'b0, result_out} + {1'b0, a_q};
        raw_res = sum_ext[WIDTH-1:0];
        ovf_c   = sum_ext[WIDTH];
      end
    endcase
  end

  // control edge capture, operand latching, result/status bookkeeping
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      result_out <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ctrl_q  <= ctrl_in[3:0];
      state_q <= state_d;
      if (clear_p) begin
        result_out <= '0;
        done_q     <= 1'b0;
        ovf_q      <= 1'b0;
        drop_q     <= 1'b0;
        cnt_q      <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: if (start_p) begin
            a_q    <= op_a;
            b_q    <= op_b;
            op_q   <= op_t'(ctrl_in[CTRL_OP_LSB +: 2]);
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
          S_EXEC: if (start_p) drop_q <= 1'b1;
          S_DONE: begin
            if (start_p) drop_q <= 1'b1;
            result_out <= saturate(raw_res, ovf_c, op_q);
            ovf_q      <= ovf_c;
            done_q     <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // status wire assembly; unused bits stay zero
  always_comb begin
    status_out = '0;
    status_out[STAT_BUSY] = (state_q != S_IDLE);
    status_out[STAT_DONE] = done_q;
    status_out[STAT_OVF]  = ovf_q;
    status_out[STAT_DROP] = drop_q;
    status_out[STAT_CNT_LSB +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_wire_alu_engine.sv
// Scoreboard bench for wire_alu_engine: stimulus pushes expected responses,
// a monitor pops them when done rises (with latency check) or one edge later
// for immediate state checks.
module tb_wire_alu_engine;

  logic        okClk;
  logic        rst_n;
  logic [31:0] ctrl_in;
  logic [31:0] op_a, op_b;
  logic [31:0] result_out;
  logic [31:0] status_out;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // completion expectations
  string       qd_name[$];
  logic [31:0] qd_res[$];
  logic [31:0] qd_stat[$];
  int          qd_cyc[$];
  // next-edge expectations
  string       qn_name[$];
  logic [31:0] qn_res[$];
  logic [31:0] qn_stat[$];

`ifdef WIRE_ALU_SATURATE_EN
  localparam logic [31:0] ADD_OVF_RES = 32'hFFFF_FFFF;
  localparam logic [31:0] SUB_OVF_RES = 32'h0000_0000;
  localparam logic [31:0] MUL_OVF_RES = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] ADD_OVF_RES = 32'h0000_0001;
  localparam logic [31:0] SUB_OVF_RES = 32'hFFFF_FFFE;
  localparam logic [31:0] MUL_OVF_RES = 32'h0000_0000;
`endif

  wire_alu_engine #(.WIDTH(32), .CNT_W(8)) dut (
    .okClk      (okClk),
    .rst_n      (rst_n),
    .ctrl_in    (ctrl_in),
    .op_a       (op_a),
    .op_b       (op_b),
    .result_out (result_out),
    .status_out (status_out)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;
  always @(posedge okClk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_done(input string nm, input logic [31:0] r, input logic [31:0] st,
                             input int at_cyc);
    qd_name.push_back(nm);
    qd_res.push_back(r);
    qd_stat.push_back(st);
    qd_cyc.push_back(at_cyc);
  endtask

  task automatic expect_now(input string nm, input logic [31:0] r, input logic [31:0] st);
    qn_name.push_back(nm);
    qn_res.push_back(r);
    qn_stat.push_back(st);
  endtask

  // one operation with a single-cycle start pulse; waits until it completes
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [31:0] st, input string nm);
    int lat;
    lat = (op == 2'b10) ? 33 : 2;
    @(negedge okClk);
    op_a = a;
    op_b = b;
    ctrl_in = {28'd0, 1'b0, op, 1'b1};
    expect_done(nm, r, st, cyc + 1 + lat);
    @(negedge okClk);
    ctrl_in[0] = 1'b0;
    repeat (lat + 2) @(negedge okClk);
  endtask

  task automatic pulse_clear(input string nm);
    @(negedge okClk);
    ctrl_in = 32'h8;
    expect_now(nm, 32'h0, 32'h0);
    @(negedge okClk);
    ctrl_in = 32'h0;
  endtask

  // monitor: sample 2ns after each rising edge
  initial begin
    logic prev_done;
    logic cur_done;
    prev_done = 1'b0;
    forever begin
      @(posedge okClk);
      #2;
      if (qn_name.size() > 0) begin
        string nm;
        nm = qn_name.pop_front();
        cmp({nm, "_result"}, result_out, qn_res.pop_front());
        cmp({nm, "_status"}, status_out, qn_stat.pop_front());
      end
      cur_done = status_out[1];
      if (cur_done && !prev_done) begin
        if (qd_name.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got result 0x%08h status 0x%08h, required no completion",
                   result_out, status_out);
        end else begin
          string nm;
          nm = qd_name.pop_front();
          cmp({nm, "_result"}, result_out, qd_res.pop_front());
          cmp({nm, "_status"}, status_out, qd_stat.pop_front());
          cmp({nm, "_latency_cycle"}, cyc, qd_cyc.pop_front());
        end
      end
      prev_done = cur_done;
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    ctrl_in = 32'h0;
    op_a = 32'h0;
    op_b = 32'h0;
    repeat (2) @(negedge okClk);
    expect_now("reset", 32'h0, 32'h0);
    @(negedge okClk);
    rst_n = 1'b1;
    repeat (2) @(negedge okClk);

    run_op(2'b00, 32'hFFFF_FFFF, 32'h2, ADD_OVF_RES, 32'h0000_0106, "add_ovf");
    run_op(2'b01, 32'h3, 32'h5, SUB_OVF_RES, 32'h0000_0206, "sub_borrow");
    run_op(2'b10, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 32'h0000_0302, "mul");
    run_op(2'b10, 32'h0001_0000, 32'h0001_0000, MUL_OVF_RES, 32'h0000_0406, "mul_ovf");
    run_op(2'b00, 32'h1234, 32'h4321, 32'h5555, 32'h0000_0502, "add");

    pulse_clear("clear");
    run_op(2'b11, 32'h5, 32'h77, 32'd5, 32'h0000_0102, "acc1");
    run_op(2'b11, 32'h5, 32'h77, 32'd10, 32'h0000_0202, "acc2");
    run_op(2'b11, 32'h5, 32'h77, 32'd15, 32'h0000_0302, "acc3");

    // start held high: exactly one accumulate
    @(negedge okClk);
    op_a = 32'h5;
    ctrl_in = 32'h7;
    expect_done("acc_held", 32'd20, 32'h0000_0402, cyc + 3);
    repeat (12) @(negedge okClk);
    expect_now("acc_held_level", 32'd20, 32'h0000_0402);
    @(negedge okClk);
    ctrl_in = 32'h0;
    repeat (2) @(negedge okClk);

    // start while MUL busy: dropped, operands change underneath
    pulse_clear("clear2");
    @(negedge okClk);
    op_a = 32'd7;
    op_b = 32'd9;
    ctrl_in = 32'h5;
    expect_done("mul_busy", 32'd63, 32'h0000_010A, cyc + 34);
    @(negedge okClk);
    ctrl_in = 32'h4;
    repeat (4) @(negedge okClk);
    op_a = 32'd100;
    op_b = 32'd100;
    ctrl_in = 32'h1;
    @(negedge okClk);
    ctrl_in = 32'h0;
    repeat (35) @(negedge okClk);

    // start and clear together: clear wins, nothing runs
    @(negedge okClk);
    op_a = 32'h1;
    op_b = 32'h1;
    ctrl_in = 32'h9;
    expect_now("clr_start", 32'h0, 32'h0);
    repeat (5) @(negedge okClk);
    expect_now("clr_start_idle", 32'h0, 32'h0);
    @(negedge okClk);
    ctrl_in = 32'h0;
    repeat (4) @(negedge okClk);

    // reset during MUL execution
    @(negedge okClk);
    op_a = 32'h3;
    op_b = 32'h3;
    ctrl_in = 32'h5;
    @(negedge okClk);
    ctrl_in = 32'h4;
    repeat (4) @(negedge okClk);
    rst_n = 1'b0;
    expect_now("rst_mid_mul", 32'h0, 32'h0);
    repeat (3) @(negedge okClk);
    rst_n = 1'b1;
    repeat (40) @(negedge okClk);
    expect_now("rst_idle", 32'h0, 32'h0);
    @(negedge okClk);
    run_op(2'b00, 32'h2, 32'h3, 32'd5, 32'h0000_0102, "add_after_rst");

    repeat (4) @(negedge okClk);
    while (qd_name.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_done_%s: got no completion, required one", qd_name.pop_front());
    end
    while (qn_name.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_check_%s: got no sample, required one", qn_name.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    repeat (5000) @(posedge okClk);
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got no end of stimulus after 5000 cycles, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
